// File: rtl/nn_mac_pkg.sv
// Shared definitions for the NN multiply-accumulate datapath: default widths,
// accumulator state encoding and the unsigned saturation helper.
package nn_mac_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int OUT_W_DEF  = 32;
  localparam int SAT_W      = 128;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_t;

  // Clamp an unsigned value to the largest number representable in width bits.
  function automatic logic [SAT_W-1:0] sat_u(input logic [SAT_W-1:0] value, input int width);
    logic [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << width) - SAT_W'(1);
    return (value > max_v) ? max_v : value;
  endfunction

endpackage

// File: rtl/mac_in_reg.sv
// One-deep product register that cuts the multiplier-to-adder timing path.
// Accepts a new beat whenever it is empty or the accumulator is consuming.
module mac_in_reg
  import nn_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  input  logic              consume,
  input  logic              accum_state,
  output logic              in_ready,
  output logic [PROD_W-1:0] p_reg,
  output logic              p_vld
);

  logic accept;

  // Only registered state feeds in_ready, so no path from in_valid.
  assign in_ready = !p_vld || accum_state;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      p_vld <= 1'b0;
    end else if (clr) begin
      p_vld <= 1'b0;
    end else if (accept) begin
      p_reg <= in_product;
      p_vld <= 1'b1;
    end else if (consume) begin
      p_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums VEC_LEN consecutive unsigned products into one dot-product result and
// presents it as exact sum, 32-bit saturated value and overflow flag.
//
// state | meaning
// ACCUM | adding registered products into acc, counting beats
// DONE  | result held in acc, waiting for out_ready
module mac_accumulator
  import nn_mac_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 68
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [OUT_W-1:0]  out_sat,
  output logic              out_ovf
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  if (VEC_LEN < 1 || VEC_LEN > 65536) begin : g_vec_len_chk
    $error("mac_accumulator: VEC_LEN out of range 1..65536");
  end
  if (ACC_W < PROD_W + $clog2(VEC_LEN)) begin : g_acc_w_chk
    $error("mac_accumulator: ACC_W too narrow for PROD_W and VEC_LEN");
  end
  if (ACC_W <= OUT_W || ACC_W > SAT_W) begin : g_out_w_chk
    $error("mac_accumulator: ACC_W must exceed OUT_W and fit the saturation helper");
  end

  mac_state_t        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] p_reg;
  logic              p_vld;
  logic              consume;

  assign consume = (state == ACCUM) && p_vld;

  mac_in_reg #(
    .PROD_W (PROD_W)
  ) u_in_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_product  (in_product),
    .consume     (consume),
    .accum_state (state == ACCUM),
    .in_ready    (in_ready),
    .p_reg       (p_reg),
    .p_vld       (p_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (p_vld) begin
            // First beat of a vector overwrites the previous result.
            acc <= (cnt == '0) ? ACC_W'(p_reg) : acc + ACC_W'(p_reg);
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_sat   = OUT_W'(sat_u(SAT_W'(acc), OUT_W));
  assign out_ovf   = |acc[ACC_W-1:OUT_W];

endmodule
